// File: rtl/btb_pkg.sv
// Shared types and sizes for the BTB write-side update engine.
//   PC_W        : PC / target width
//   INDEX_BITS  : set index width, index = pc[INDEX_BITS+1:2]
//   TAG_W       : tag width, tag = pc[PC_W-1:INDEX_BITS+2]
//   btb_upd_t   : one resolved branch waiting to be written into the BTB
//   upd_state_e : update FSM states
package btb_pkg;

   localparam int PC_W       = 32;
   localparam int INDEX_BITS = 3;
   localparam int TAG_W      = PC_W - INDEX_BITS - 2;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] target;
      logic            taken;
   } btb_upd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      CMP  = 2'd2,
      WR   = 2'd3
   } upd_state_e;

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of pending BTB updates.
//   clk, rst : clock, synchronous active-high reset (empties the queue)
//   push_i   : enqueue data_i (ignored when full unless popping this cycle)
//   pop_i    : dequeue head (ignored when empty)
//   data_i   : entry to enqueue
//   data_o   : current head entry (valid when !empty_o)
//   empty_o  : queue holds no entries
//   full_o   : queue holds DEPTH entries
// A push and a pop may happen together even when full.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push_i,
   input  logic     pop_i,
   input  btb_upd_t data_i,
   output btb_upd_t data_o,
   output logic     empty_o,
   output logic     full_o
);

   localparam int           PW     = $clog2(DEPTH);
   localparam logic [PW-1:0] PONE_C = PW'(1);
   localparam logic [PW:0]   CONE_C = (PW + 1)'(1);
   localparam logic [PW:0]   FULL_C = (PW + 1)'(DEPTH);

   btb_upd_t       mem_q [DEPTH];
   logic [PW-1:0]  wptr_q, wptr_d;
   logic [PW-1:0]  rptr_q, rptr_d;
   logic [PW:0]    cnt_q,  cnt_d;
   logic           do_push_s;
   logic           do_pop_s;

   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == FULL_C);
   assign do_pop_s  = pop_i && !empty_o;
   // When full, a push is only safe if the head leaves in the same cycle.
   assign do_push_s = push_i && (!full_o || do_pop_s);
   assign data_o    = mem_q[rptr_q];

   // Pointer and occupancy next-state.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push_s) begin
         wptr_d = wptr_q + PONE_C;
      end else begin
         wptr_d = wptr_q;
      end
      if (do_pop_s) begin
         rptr_d = rptr_q + PONE_C;
      end else begin
         rptr_d = rptr_q;
      end
      if (do_push_s && !do_pop_s) begin
         cnt_d = cnt_q + CONE_C;
      end else if (!do_push_s && do_pop_s) begin
         cnt_d = cnt_q - CONE_C;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage; contents are don't-care while the slot is not occupied.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/btb_update_ctrl_chk.sv
// Property checker for the BTB update engine.
//   clk, rst : clock, synchronous active-high reset
//   in_cmp_i : FSM is in the tag-compare state
//   hit0_i   : raw way0 tag match
//   hit1_i   : raw way1 tag match
//   wr_en_i  : BTB write strobe
//   lru_upd_i: LRU update strobe
module btb_update_ctrl_chk (
   input logic clk,
   input logic rst,
   input logic in_cmp_i,
   input logic hit0_i,
   input logic hit1_i,
   input logic wr_en_i,
   input logic lru_upd_i
);

   // A branch may live in at most one way of its set.
   a_no_dual_hit : assert property (@(posedge clk) disable iff (rst)
      in_cmp_i |-> !(hit0_i && hit1_i));

   // The LRU tracker is told about every write and nothing else.
   a_lru_with_wr : assert property (@(posedge clk) disable iff (rst)
      wr_en_i == lru_upd_i);

endmodule

// File: rtl/btb_update_ctrl.sv
// EX-stage write-side engine of the 2-way set-associative BTB.
// Resolved branches are queued, then one at a time: read the indexed set,
// compare tags, choose a way (hit way, else lowest free way, else the LRU
// victim) and write the entry while notifying the LRU tracker.
//   ex_valid/ex_ready/ex_pc/ex_target/ex_taken : resolved branch input
//   rd_en/rd_index                             : BTB set read request
//   rd_valid/rd_tag0/rd_tag1/lru_bit           : read data, 1 cycle later
//   wr_en/wr_index/wr_way/wr_valid/wr_tag/wr_target : BTB write (registered)
//   lru_upd/lru_upd_index/lru_upd_hit0/1       : LRU touch (registered)
module btb_update_ctrl
   import btb_pkg::*;
#(
   parameter int PC_W       = btb_pkg::PC_W,
   parameter int INDEX_BITS = btb_pkg::INDEX_BITS,
   parameter int FIFO_DEPTH = 2,
   parameter int TAG_W      = PC_W - INDEX_BITS - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [PC_W-1:0]       ex_pc,
   input  logic [PC_W-1:0]       ex_target,
   input  logic                  ex_taken,
   output logic                  rd_en,
   output logic [INDEX_BITS-1:0] rd_index,
   input  logic [1:0]            rd_valid,
   input  logic [TAG_W-1:0]      rd_tag0,
   input  logic [TAG_W-1:0]      rd_tag1,
   input  logic                  lru_bit,
   output logic                  wr_en,
   output logic [INDEX_BITS-1:0] wr_index,
   output logic                  wr_way,
   output logic                  wr_valid,
   output logic [TAG_W-1:0]      wr_tag,
   output logic [PC_W-1:0]       wr_target,
   output logic                  lru_upd,
   output logic [INDEX_BITS-1:0] lru_upd_index,
   output logic                  lru_upd_hit0,
   output logic                  lru_upd_hit1
);

   upd_state_e            state_q, state_d;
   btb_upd_t              hold_q, hold_d;
   btb_upd_t              enq_s, head_s;
   logic                  fifo_empty_s, fifo_full_s;
   logic                  fifo_push_s, fifo_pop_s;
   logic [INDEX_BITS-1:0] hold_index_s;
   logic [TAG_W-1:0]      hold_tag_s;
   logic                  raw_hit0_s, raw_hit1_s;
   logic                  hit0_s, hit1_s;
   logic                  do_wr_s;
   logic                  sel_way_s;
   logic                  unused_pc_lsb_s;

   logic                  wr_en_q, wr_en_d;
   logic [INDEX_BITS-1:0] wr_index_q, wr_index_d;
   logic                  wr_way_q, wr_way_d;
   logic                  wr_valid_q, wr_valid_d;
   logic [TAG_W-1:0]      wr_tag_q, wr_tag_d;
   logic [PC_W-1:0]       wr_target_q, wr_target_d;
   logic                  hit0_q, hit0_d;
   logic                  hit1_q, hit1_d;

   // ---------------- pending-update queue ----------------
   assign enq_s.pc     = ex_pc;
   assign enq_s.target = ex_target;
   assign enq_s.taken  = ex_taken;

   // The head leaves only while the FSM is idle; ex_ready also covers the
   // full-queue case where that pop frees a slot in the same cycle.
   assign fifo_pop_s  = (state_q == IDLE) && !fifo_empty_s;
   assign ex_ready    = !fifo_full_s || fifo_pop_s;
   assign fifo_push_s = ex_valid && ex_ready;

   btb_upd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push_s),
      .pop_i   (fifo_pop_s),
      .data_i  (enq_s),
      .data_o  (head_s),
      .empty_o (fifo_empty_s),
      .full_o  (fifo_full_s)
   );

   // ---------------- holding register ----------------
   assign hold_index_s    = hold_q.pc[INDEX_BITS+1:2];
   assign hold_tag_s      = hold_q.pc[PC_W-1:INDEX_BITS+2];
   assign unused_pc_lsb_s = ^hold_q.pc[1:0];

   // Capture the queue head as it is popped.
   always_comb begin
      hold_d = hold_q;
      if (fifo_pop_s) begin
         hold_d = head_s;
      end else begin
         hold_d = hold_q;
      end
   end

   // Holding register storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   // ---------------- tag compare and way selection ----------------
   assign raw_hit0_s = rd_valid[0] && (rd_tag0 == hold_tag_s);
   assign raw_hit1_s = rd_valid[1] && (rd_tag1 == hold_tag_s);
   // A double hit is resolved in favour of way0.
   assign hit0_s     = raw_hit0_s;
   assign hit1_s     = raw_hit1_s && !raw_hit0_s;

   // Write decision made in CMP; everything is zero outside that state.
   always_comb begin
      do_wr_s   = 1'b0;
      sel_way_s = 1'b0;
      if (state_q == CMP) begin
         if (hit0_s) begin
            do_wr_s   = 1'b1;
            sel_way_s = 1'b0;
         end else if (hit1_s) begin
            do_wr_s   = 1'b1;
            sel_way_s = 1'b1;
         end else if (hold_q.taken) begin
            do_wr_s = 1'b1;
            if (!rd_valid[0]) begin
               sel_way_s = 1'b0;
            end else if (!rd_valid[1]) begin
               sel_way_s = 1'b1;
            end else begin
               // lru_bit names the most recent way; replace the other one.
               sel_way_s = !lru_bit;
            end
         end else begin
            do_wr_s   = 1'b0;
            sel_way_s = 1'b0;
         end
      end else begin
         do_wr_s   = 1'b0;
         sel_way_s = 1'b0;
      end
   end

   // Next values of the registered write / LRU outputs.
   always_comb begin
      wr_en_d     = 1'b0;
      wr_index_d  = '0;
      wr_way_d    = 1'b0;
      wr_valid_d  = 1'b0;
      wr_tag_d    = '0;
      wr_target_d = '0;
      hit0_d      = 1'b0;
      hit1_d      = 1'b0;
      if (do_wr_s) begin
         wr_en_d     = 1'b1;
         wr_index_d  = hold_index_s;
         wr_way_d    = sel_way_s;
         // Not-taken only reaches here on a hit: that entry is invalidated.
         wr_valid_d  = hold_q.taken;
         wr_tag_d    = hold_tag_s;
         wr_target_d = hold_q.target;
         hit0_d      = hit0_s;
         hit1_d      = hit1_s;
      end else begin
         wr_en_d = 1'b0;
      end
   end

   // Output registers for the BTB write and LRU update ports.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q     <= 1'b0;
         wr_index_q  <= '0;
         wr_way_q    <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_tag_q    <= '0;
         wr_target_q <= '0;
         hit0_q      <= 1'b0;
         hit1_q      <= 1'b0;
      end else begin
         wr_en_q     <= wr_en_d;
         wr_index_q  <= wr_index_d;
         wr_way_q    <= wr_way_d;
         wr_valid_q  <= wr_valid_d;
         wr_tag_q    <= wr_tag_d;
         wr_target_q <= wr_target_d;
         hit0_q      <= hit0_d;
         hit1_q      <= hit1_d;
      end
   end

   assign wr_en         = wr_en_q;
   assign wr_index      = wr_index_q;
   assign wr_way        = wr_way_q;
   assign wr_valid      = wr_valid_q;
   assign wr_tag        = wr_tag_q;
   assign wr_target     = wr_target_q;
   assign lru_upd       = wr_en_q;
   assign lru_upd_index = wr_index_q;
   assign lru_upd_hit0  = hit0_q;
   assign lru_upd_hit1  = hit1_q;

   // ---------------- FSM ----------------
   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty_s) begin
               state_d = RD;
            end else begin
               state_d = IDLE;
            end
         end
         RD:  state_d = CMP;
         CMP: begin
            if (do_wr_s) begin
               state_d = WR;
            end else begin
               state_d = IDLE;
            end
         end
         WR:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read-request outputs.
   always_comb begin
      rd_en    = 1'b0;
      rd_index = '0;
      case (state_q)
         RD: begin
            rd_en    = 1'b1;
            rd_index = hold_index_s;
         end
         default: begin
            rd_en    = 1'b0;
            rd_index = '0;
         end
      endcase
   end

   btb_update_ctrl_chk u_chk (
      .clk       (clk),
      .rst       (rst),
      .in_cmp_i  (state_q == CMP),
      .hit0_i    (raw_hit0_s),
      .hit1_i    (raw_hit1_s),
      .wr_en_i   (wr_en_q),
      .lru_upd_i (wr_en_q)
   );

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: stimulus pushes expected reads and
// writes into queues, a negedge monitor pops and compares them.
module tb_btb_update_ctrl;

   localparam int PW = 32;
   localparam int IB = 3;
   localparam int TW = 27;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ex_valid = 1'b0;
   logic          ex_ready;
   logic [PW-1:0] ex_pc = '0;
   logic [PW-1:0] ex_target = '0;
   logic          ex_taken = 1'b0;
   logic          rd_en;
   logic [IB-1:0] rd_index;
   logic [1:0]    rd_valid = 2'b00;
   logic [TW-1:0] rd_tag0 = '0;
   logic [TW-1:0] rd_tag1 = '0;
   logic          lru_bit = 1'b0;
   logic          wr_en;
   logic [IB-1:0] wr_index;
   logic          wr_way;
   logic          wr_valid;
   logic [TW-1:0] wr_tag;
   logic [PW-1:0] wr_target;
   logic          lru_upd;
   logic [IB-1:0] lru_upd_index;
   logic          lru_upd_hit0;
   logic          lru_upd_hit1;

   btb_update_ctrl dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_target(ex_target), .ex_taken(ex_taken),
      .rd_en(rd_en), .rd_index(rd_index), .rd_valid(rd_valid),
      .rd_tag0(rd_tag0), .rd_tag1(rd_tag1), .lru_bit(lru_bit),
      .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way),
      .wr_valid(wr_valid), .wr_tag(wr_tag), .wr_target(wr_target),
      .lru_upd(lru_upd), .lru_upd_index(lru_upd_index),
      .lru_upd_hit0(lru_upd_hit0), .lru_upd_hit1(lru_upd_hit1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bench-owned BTB contents, preset by each test.
   logic [1:0]    m_valid [8];
   logic [TW-1:0] m_tag0  [8];
   logic [TW-1:0] m_tag1  [8];
   logic          m_lru   [8];

   // BTB read port: data appears after the RD cycle and holds through CMP.
   always @(negedge clk) begin
      if (rd_en === 1'b1) begin
         rd_valid = m_valid[rd_index];
         rd_tag0  = m_tag0[rd_index];
         rd_tag1  = m_tag1[rd_index];
         lru_bit  = m_lru[rd_index];
      end
   end

   typedef struct {
      int            cyc;
      logic [IB-1:0] idx;
   } rd_exp_t;

   typedef struct {
      int            cyc;
      logic [IB-1:0] idx;
      logic          way;
      logic          valid;
      logic [TW-1:0] tag;
      logic [PW-1:0] tgt;
      logic          h0;
      logic          h1;
   } wr_exp_t;

   rd_exp_t rq[$];
   wr_exp_t wq[$];
   int n_cmp = 0;
   int n_bad = 0;

   rd_exp_t r_m;
   wr_exp_t w_m;
   logic    w_ok;

   // Monitor: every read/write the DUT presents must match the queue head.
   always @(negedge clk) begin
      if (rd_en === 1'b1) begin
         n_cmp++;
         if (rq.size() == 0) begin
            n_bad++;
            $display("FAIL rd_unexpected: rd_en=1 idx=%0d cyc=%0d, required no read", rd_index, cyc);
         end else begin
            r_m = rq.pop_front();
            if (rd_index !== r_m.idx || cyc != r_m.cyc) begin
               n_bad++;
               $display("FAIL rd_check: got idx=%0d cyc=%0d, required idx=%0d cyc=%0d",
                        rd_index, cyc, r_m.idx, r_m.cyc);
            end
         end
      end
      if (wr_en !== 1'b0 || lru_upd !== 1'b0) begin
         n_cmp++;
         if (wq.size() == 0) begin
            n_bad++;
            $display("FAIL wr_unexpected: wr_en=%b lru_upd=%b cyc=%0d, required no write", wr_en, lru_upd, cyc);
         end else begin
            w_m  = wq.pop_front();
            w_ok = (wr_en === 1'b1) && (lru_upd === 1'b1) && (cyc == w_m.cyc) &&
                   (wr_index === w_m.idx) && (lru_upd_index === w_m.idx) &&
                   (wr_way === w_m.way) && (wr_valid === w_m.valid) &&
                   (wr_tag === w_m.tag) && (lru_upd_hit0 === w_m.h0) &&
                   (lru_upd_hit1 === w_m.h1) && (wr_target === w_m.tgt);
            if (!w_ok) begin
               n_bad++;
               $display("FAIL wr_check: got en=%b lru=%b cyc=%0d idx=%0d/%0d way=%b v=%b tag=%h tgt=%h h=%b%b, required cyc=%0d idx=%0d way=%b v=%b tag=%h tgt=%h h=%b%b",
                        wr_en, lru_upd, cyc, wr_index, lru_upd_index, wr_way, wr_valid, wr_tag, wr_target,
                        lru_upd_hit0, lru_upd_hit1, w_m.cyc, w_m.idx, w_m.way, w_m.valid, w_m.tag, w_m.tgt,
                        w_m.h0, w_m.h1);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      n_cmp++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic exp_rd(input int c, input logic [IB-1:0] idx);
      rd_exp_t e;
      e.cyc = c; e.idx = idx;
      rq.push_back(e);
   endtask

   task automatic exp_wr(input int c, input logic [IB-1:0] idx, input logic way, input logic v,
                         input logic [TW-1:0] tag, input logic [PW-1:0] tgt, input logic h0, input logic h1);
      wr_exp_t e;
      e.cyc = c; e.idx = idx; e.way = way; e.valid = v;
      e.tag = tag; e.tgt = tgt; e.h0 = h0; e.h1 = h1;
      wq.push_back(e);
   endtask

   // Offer one update (called at a negedge); returns the accepting cycle.
   task automatic offer(input logic [PW-1:0] pc, input logic [PW-1:0] tgt, input logic tk, output int acc);
      int g;
      ex_pc = pc; ex_target = tgt; ex_taken = tk; ex_valid = 1'b1;
      g = 0;
      while (ex_ready !== 1'b1 && g < 40) begin
         @(negedge clk);
         g++;
      end
      check("accept_timeout", (g >= 40) ? 32'd1 : 32'd0, 32'd0);
      acc = cyc;
      @(negedge clk);
      ex_valid = 1'b0;
   endtask

   // Wait until every expected transaction has been seen.
   task automatic drain();
      int g;
      g = 0;
      while ((rq.size() != 0 || wq.size() != 0) && g < 60) begin
         @(negedge clk);
         g++;
      end
      check("drain_timeout", (g >= 60) ? 32'd1 : 32'd0, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   int n;
   int acc [4];
   int stall;
   logic [PW-1:0] b_pc [4];

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 2'b00; m_tag0[i] = '0; m_tag1[i] = '0; m_lru[i] = 1'b0;
      end

      // 1. Reset held two cycles.
      repeat (2) @(negedge clk);
      check("reset_ex_ready", {31'd0, ex_ready}, 32'd1);
      check("reset_rd_en",    {31'd0, rd_en},    32'd0);
      check("reset_wr_en",    {31'd0, wr_en},    32'd0);
      check("reset_lru_upd",  {31'd0, lru_upd},  32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 2. Taken miss into empty set 3: pc 0x4C -> idx 3, tag 2, way0.
      exp_rd(cyc + 2, 3'd3);
      exp_wr(cyc + 4, 3'd3, 1'b0, 1'b1, 27'd2, 32'h100, 1'b0, 1'b0);
      offer(32'h4C, 32'h100, 1'b1, n);
      drain();

      // 3. Full set 3 (tags 2,5), pc 0x6C (tag 3) misses: victim = !lru_bit.
      m_valid[3] = 2'b11; m_tag0[3] = 27'd2; m_tag1[3] = 27'd5; m_lru[3] = 1'b0;
      exp_rd(cyc + 2, 3'd3);
      exp_wr(cyc + 4, 3'd3, 1'b1, 1'b1, 27'd3, 32'h300, 1'b0, 1'b0);
      offer(32'h6C, 32'h300, 1'b1, n);
      drain();
      m_lru[3] = 1'b1;
      exp_rd(cyc + 2, 3'd3);
      exp_wr(cyc + 4, 3'd3, 1'b0, 1'b1, 27'd3, 32'h304, 1'b0, 1'b0);
      offer(32'h6C, 32'h304, 1'b1, n);
      drain();

      // Only way1 free in set 5: pc 0xF4 -> idx 5, tag 7, goes to way1.
      m_valid[5] = 2'b01; m_tag0[5] = 27'd1;
      exp_rd(cyc + 2, 3'd5);
      exp_wr(cyc + 4, 3'd5, 1'b1, 1'b1, 27'd7, 32'h500, 1'b0, 1'b0);
      offer(32'hF4, 32'h500, 1'b1, n);
      drain();

      // 4. Set 3 tags {2,3}: taken hit way1, not-taken hit way0, not-taken miss.
      m_valid[3] = 2'b11; m_tag0[3] = 27'd2; m_tag1[3] = 27'd3; m_lru[3] = 1'b0;
      exp_rd(cyc + 2, 3'd3);
      exp_wr(cyc + 4, 3'd3, 1'b1, 1'b1, 27'd3, 32'h200, 1'b0, 1'b1);
      offer(32'h6C, 32'h200, 1'b1, n);
      drain();
      exp_rd(cyc + 2, 3'd3);
      exp_wr(cyc + 4, 3'd3, 1'b0, 1'b0, 27'd2, 32'h44, 1'b1, 1'b0);
      offer(32'h4C, 32'h44, 1'b0, n);
      drain();
      exp_rd(cyc + 2, 3'd3);
      offer(32'h8C, 32'h88, 1'b0, n);
      drain();

      // 5. Four back-to-back updates with ex_valid held high.
      b_pc[0] = 32'h20; b_pc[1] = 32'h24; b_pc[2] = 32'h28; b_pc[3] = 32'h30;
      n = 0; stall = 0;
      ex_valid = 1'b1; ex_taken = 1'b1;
      for (int g = 0; g < 60 && n < 4; g++) begin
         ex_pc = b_pc[n]; ex_target = 32'h1000 + 32'(n * 4);
         if (ex_ready === 1'b1) begin
            acc[n] = cyc;
            exp_rd(acc[0] + 2 + 4 * n, b_pc[n][4:2]);
            exp_wr(acc[0] + 4 + 4 * n, b_pc[n][4:2], 1'b0, 1'b1, 27'd1, 32'h1000 + 32'(n * 4), 1'b0, 1'b0);
            n++;
         end else begin
            stall++;
         end
         @(negedge clk);
      end
      ex_valid = 1'b0;
      check("b2b_acc1",  acc[1] - acc[0], 32'd1);
      check("b2b_acc2",  acc[2] - acc[0], 32'd2);
      check("b2b_acc3",  acc[3] - acc[0], 32'd5);
      check("b2b_stall", stall, 32'd2);
      drain();

      // 6. Reset while the first of three is in CMP with two still queued.
      b_pc[0] = 32'h38; b_pc[1] = 32'h58; b_pc[2] = 32'h78;
      n = 0;
      ex_valid = 1'b1; ex_taken = 1'b1;
      for (int g = 0; g < 30 && n < 3; g++) begin
         ex_pc = b_pc[n]; ex_target = 32'h600;
         if (ex_ready === 1'b1) begin
            acc[n] = cyc;
            if (n == 0) exp_rd(acc[0] + 2, 3'd6);
            n++;
         end
         @(negedge clk);
      end
      ex_valid = 1'b0;
      check("rst_at_cmp_cycle", cyc - acc[0], 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("post_rst_ex_ready", {31'd0, ex_ready}, 32'd1);
      check("post_rst_wr_en",    {31'd0, wr_en},    32'd0);
      repeat (8) @(negedge clk);
      check("post_rst_ex_ready_idle", {31'd0, ex_ready}, 32'd1);
      check("post_rst_rq_empty", rq.size(), 32'd0);
      check("post_rst_wq_empty", wq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
